// File: rtl/oflow_similarity_metric_responder_if.sv
// Start/done handshake and feature-buffer read port between the score-calc
// initiator (plus its feature buffer) and the similarity-metric responder.
interface oflow_similarity_metric_responder_if #(
   parameter int FEAT_W  = 11,
   parameter int SCORE_W = 16,
   parameter int IDX_W   = 2
);
   logic               start_similarity_metric_0;
   logic               start_similarity_metric_1;
   logic               feat_rd_en;
   logic [IDX_W-1:0]   feat_rd_idx;
   logic [FEAT_W-1:0]  feat_cur;
   logic [FEAT_W-1:0]  feat_cand_0;
   logic [FEAT_W-1:0]  feat_cand_1;
   logic               busy;
   logic               done_similarity_metric;
   logic [SCORE_W-1:0] score_0;
   logic [SCORE_W-1:0] score_1;
   logic               score_1_valid;

   modport master (
      output start_similarity_metric_0, start_similarity_metric_1,
      output feat_cur, feat_cand_0, feat_cand_1,
      input  feat_rd_en, feat_rd_idx, busy, done_similarity_metric,
      input  score_0, score_1, score_1_valid
   );

   modport slave (
      input  start_similarity_metric_0, start_similarity_metric_1,
      input  feat_cur, feat_cand_0, feat_cand_1,
      output feat_rd_en, feat_rd_idx, busy, done_similarity_metric,
      output score_0, score_1, score_1_valid
   );
endinterface

// File: rtl/oflow_similarity_metric_responder.sv
// Similarity-metric responder: on start, reads FEAT_NUM feature words and
// returns a saturating sum-of-absolute-differences score for one or two lanes.
//
// state | meaning
// IDLE  | waiting for start_similarity_metric_0
// READ  | issuing feature reads, accumulating the previous index's data
// LAST  | no read issued, accumulating the final returned words
// DONE  | done pulse, scores presented
module oflow_similarity_metric_responder #(
   parameter int FEAT_NUM = 4,
   parameter int FEAT_W   = 11,
   parameter int SCORE_W  = 16,
   parameter int IDX_W    = 2
) (
   input logic clk,
   input logic reset_N,
   oflow_similarity_metric_responder_if.slave sm
);

   localparam int SUM_W = ((SCORE_W > FEAT_W) ? SCORE_W : FEAT_W) + 1;
   localparam logic [SUM_W-1:0]   SAT_SUM   = SUM_W'({SCORE_W{1'b1}});
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(FEAT_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_LAST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               rd_vld_q;
   logic               lane1_en_q, lane1_en_d;
   logic [SCORE_W-1:0] acc0_q, acc0_d;
   logic [SCORE_W-1:0] acc1_q, acc1_d;
   logic [SCORE_W-1:0] score0_q, score0_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic               score1_vld_q, score1_vld_d;
   logic               rd_en;
   logic               done;

   function automatic logic [FEAT_W-1:0] abs_diff(input logic [FEAT_W-1:0] a,
                                                  input logic [FEAT_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // One extra bit of headroom exposes the overflow before it wraps.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                 input logic [FEAT_W-1:0]  d);
      logic [SUM_W-1:0] s;
      s = SUM_W'(acc) + SUM_W'(d);
      return (s > SAT_SUM) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_N) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         rd_vld_q     <= 1'b0;
         lane1_en_q   <= 1'b0;
         acc0_q       <= '0;
         acc1_q       <= '0;
         score0_q     <= '0;
         score1_q     <= '0;
         score1_vld_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rd_vld_q     <= rd_en;
         lane1_en_q   <= lane1_en_d;
         acc0_q       <= acc0_d;
         acc1_q       <= acc1_d;
         score0_q     <= score0_d;
         score1_q     <= score1_d;
         score1_vld_q <= score1_vld_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      lane1_en_d   = lane1_en_q;
      acc0_d       = acc0_q;
      acc1_d       = acc1_q;
      score0_d     = score0_q;
      score1_d     = score1_q;
      score1_vld_d = score1_vld_q;
      rd_en        = 1'b0;
      done         = 1'b0;

      // Data returned for a read issued last cycle is folded in here.
      if (rd_vld_q) begin
         acc0_d = sat_add(acc0_q, abs_diff(sm.feat_cur, sm.feat_cand_0));
         if (lane1_en_q) begin
            acc1_d = sat_add(acc1_q, abs_diff(sm.feat_cur, sm.feat_cand_1));
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (sm.start_similarity_metric_0) begin
               lane1_en_d   = sm.start_similarity_metric_1;
               acc0_d       = '0;
               acc1_d       = '0;
               idx_d        = '0;
               score0_d     = '0;
               score1_d     = '0;
               score1_vld_d = 1'b0;
               state_d      = S_READ;
            end
         end
         S_READ: begin
            rd_en = 1'b1;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = S_LAST;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_LAST: begin
            score0_d     = acc0_d;
            score1_d     = acc1_d;
            score1_vld_d = lane1_en_q;
            state_d      = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sm.feat_rd_en             = rd_en;
   assign sm.feat_rd_idx            = (state_q == S_READ) ? idx_q : '0;
   assign sm.busy                   = (state_q != S_IDLE);
   assign sm.done_similarity_metric = done;
   assign sm.score_0                = score0_q;
   assign sm.score_1                = score1_q;
   assign sm.score_1_valid          = score1_vld_q;

endmodule

// File: tb/tb_oflow_similarity_metric_responder.sv
// Bench for the similarity-metric responder: a 16-bit-score instance and an
// 11-bit-score instance sharing one feature buffer model.
module tb_oflow_similarity_metric_responder;

   localparam int FEAT_NUM = 4;
   localparam int FEAT_W   = 11;
   localparam int IDX_W    = 2;

   typedef logic [FEAT_NUM-1:0][FEAT_W-1:0] feat4_t;

   typedef struct packed {
      logic        sel_b;
      logic        en1;
      feat4_t      cur;
      feat4_t      c0;
      feat4_t      c1;
      logic [15:0] exp0;
      logic [15:0] exp1;
      logic        exp_v;
   } vec_t;

   logic clk = 1'b0;
   logic reset_N = 1'b0;
   always #5 clk = ~clk;

   oflow_similarity_metric_responder_if #(.FEAT_W(FEAT_W), .SCORE_W(16), .IDX_W(IDX_W)) ifa ();
   oflow_similarity_metric_responder_if #(.FEAT_W(FEAT_W), .SCORE_W(11), .IDX_W(IDX_W)) ifb ();

   oflow_similarity_metric_responder #(.FEAT_NUM(FEAT_NUM), .FEAT_W(FEAT_W), .SCORE_W(16), .IDX_W(IDX_W))
      dut_a (.clk(clk), .reset_N(reset_N), .sm(ifa));
   oflow_similarity_metric_responder #(.FEAT_NUM(FEAT_NUM), .FEAT_W(FEAT_W), .SCORE_W(11), .IDX_W(IDX_W))
      dut_b (.clk(clk), .reset_N(reset_N), .sm(ifb));

   logic [FEAT_W-1:0] cur_m [FEAT_NUM];
   logic [FEAT_W-1:0] c0_m  [FEAT_NUM];
   logic [FEAT_W-1:0] c1_m  [FEAT_NUM];

   // Feature buffer: one-cycle read latency, noise when nothing was read.
   always @(posedge clk) begin
      if (ifa.feat_rd_en) begin
         ifa.feat_cur    <= cur_m[ifa.feat_rd_idx];
         ifa.feat_cand_0 <= c0_m[ifa.feat_rd_idx];
         ifa.feat_cand_1 <= c1_m[ifa.feat_rd_idx];
      end else begin
         ifa.feat_cur    <= FEAT_W'($urandom);
         ifa.feat_cand_0 <= FEAT_W'($urandom);
         ifa.feat_cand_1 <= FEAT_W'($urandom);
      end
      if (ifb.feat_rd_en) begin
         ifb.feat_cur    <= cur_m[ifb.feat_rd_idx];
         ifb.feat_cand_0 <= c0_m[ifb.feat_rd_idx];
         ifb.feat_cand_1 <= c1_m[ifb.feat_rd_idx];
      end else begin
         ifb.feat_cur    <= FEAT_W'($urandom);
         ifb.feat_cand_0 <= FEAT_W'($urandom);
         ifb.feat_cand_1 <= FEAT_W'($urandom);
      end
   end

   logic              sel = 1'b0;
   logic              o_rd, o_busy, o_done, o_v;
   logic [IDX_W-1:0]  o_idx;
   logic [15:0]       o_s0, o_s1;

   always_comb begin
      if (sel) begin
         o_rd = ifb.feat_rd_en; o_idx = ifb.feat_rd_idx; o_busy = ifb.busy;
         o_done = ifb.done_similarity_metric; o_v = ifb.score_1_valid;
         o_s0 = 16'(ifb.score_0); o_s1 = 16'(ifb.score_1);
      end else begin
         o_rd = ifa.feat_rd_en; o_idx = ifa.feat_rd_idx; o_busy = ifa.busy;
         o_done = ifa.done_similarity_metric; o_v = ifa.score_1_valid;
         o_s0 = ifa.score_0; o_s1 = ifa.score_1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_start(input logic s0, input logic s1);
      ifa.start_similarity_metric_0 = sel ? 1'b0 : s0;
      ifa.start_similarity_metric_1 = sel ? 1'b0 : s1;
      ifb.start_similarity_metric_0 = sel ? s0 : 1'b0;
      ifb.start_similarity_metric_1 = sel ? s1 : 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " rd_en"}, 32'(o_rd), 0);
      chk({tag, " idx"},   32'(o_idx), 0);
      chk({tag, " busy"},  32'(o_busy), 0);
      chk({tag, " done"},  32'(o_done), 0);
      chk({tag, " s0"},    32'(o_s0), 0);
      chk({tag, " s1"},    32'(o_s1), 0);
      chk({tag, " v"},     32'(o_v), 0);
   endtask

   function automatic feat4_t mk4(input int a, input int b, input int c, input int d);
      feat4_t f;
      f[0] = FEAT_W'(a); f[1] = FEAT_W'(b); f[2] = FEAT_W'(c); f[3] = FEAT_W'(d);
      return f;
   endfunction

   // Saturating running sum of non-negative terms equals the clamped total.
   function automatic logic [15:0] model(input feat4_t a, input feat4_t b, input int maxv);
      int s = 0;
      for (int i = 0; i < FEAT_NUM; i++) begin
         int x = int'(a[i]);
         int y = int'(b[i]);
         s += (x > y) ? (x - y) : (y - x);
      end
      return 16'((s > maxv) ? maxv : s);
   endfunction

   function automatic vec_t mkvec(input logic sb, input logic e1, input feat4_t cu,
                                  input feat4_t k0, input feat4_t k1);
      vec_t v;
      int   mx = sb ? 2047 : 65535;
      v.sel_b = sb; v.en1 = e1; v.cur = cu; v.c0 = k0; v.c1 = k1;
      v.exp0  = model(cu, k0, mx);
      v.exp1  = e1 ? model(cu, k1, mx) : 16'd0;
      v.exp_v = e1;
      return v;
   endfunction

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < FEAT_NUM; i++) begin
         cur_m[i] = v.cur[i]; c0_m[i] = v.c0[i]; c1_m[i] = v.c1[i];
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      @(negedge clk);
      sel = v.sel_b;
      load_mem(v);
      set_start(1'b1, v.en1);
      for (int k = 1; k <= FEAT_NUM + 3; k++) begin
         @(posedge clk);
         #1;
         set_start(1'b0, 1'b0);
         if (k == 1) begin
            chk({tag, " s0 cleared"}, 32'(o_s0), 0);
            chk({tag, " v cleared"},  32'(o_v), 0);
         end
         if (k <= FEAT_NUM) chk({tag, " idx"}, 32'(o_idx), 32'(k - 1));
         chk({tag, " rd_en"}, 32'(o_rd), 32'(k <= FEAT_NUM));
         chk({tag, " busy"},  32'(o_busy), 32'(k <= FEAT_NUM + 2));
         chk({tag, " done"},  32'(o_done), 32'(k == FEAT_NUM + 2));
         if (k >= FEAT_NUM + 2) begin
            chk({tag, " score_0"},       32'(o_s0), 32'(v.exp0));
            chk({tag, " score_1"},       32'(o_s1), 32'(v.exp1));
            chk({tag, " score_1_valid"}, 32'(o_v),  32'(v.exp_v));
         end
      end
   endtask

   vec_t vecs[$];

   initial begin
      set_start(1'b0, 1'b0);
      for (int i = 0; i < FEAT_NUM; i++) begin
         cur_m[i] = '0; c0_m[i] = '0; c1_m[i] = '0;
      end

      vecs.push_back(mkvec(1'b0, 1'b0, mk4(10, 20, 30, 40), mk4(12, 15, 30, 50), mk4(0, 0, 0, 0)));
      vecs.push_back(mkvec(1'b0, 1'b1, mk4(100, 0, 2047, 5), mk4(0, 0, 0, 5), mk4(100, 1, 2047, 6)));
      vecs.push_back(mkvec(1'b1, 1'b0, mk4(2047, 2047, 2047, 2047), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0)));
      vecs.push_back(mkvec(1'b1, 1'b1, mk4(0, 0, 0, 0), mk4(2047, 0, 0, 0), mk4(2047, 2047, 0, 0)));
      for (int n = 0; n < 24; n++) begin
         feat4_t cu, k0, k1;
         for (int i = 0; i < FEAT_NUM; i++) begin
            cu[i] = FEAT_W'($urandom); k0[i] = FEAT_W'($urandom); k1[i] = FEAT_W'($urandom);
         end
         vecs.push_back(mkvec(1'($urandom), 1'($urandom), cu, k0, k1));
      end

      // Reset held three cycles, then a long idle stretch.
      reset_N = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0; #1; chk_zero("rst_a");
      sel = 1'b1; #1; chk_zero("rst_b");
      @(negedge clk);
      reset_N = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("idle done_a", 32'(ifa.done_similarity_metric | ifb.done_similarity_metric), 0);
         chk("idle busy",   32'(ifa.busy | ifb.busy), 0);
      end

      // start_1 on its own must not start anything.
      @(negedge clk);
      sel = 1'b0;
      ifa.start_similarity_metric_1 = 1'b1;
      @(posedge clk); #1;
      chk("start1 alone busy", 32'(o_busy), 0);
      set_start(1'b0, 1'b0);

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Ignored starts at cycles 3 and 6, back-to-back start at cycle 7.
      sel = 1'b0;
      load_mem(vecs[0]);
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         set_start((c == 0) || (c == 3) || (c == 6) || (c == 7), 1'b1);
         @(posedge clk); #1;
         chk($sformatf("b2b done c%0d", c + 1), 32'(o_done), 32'((c + 1 == 6) || (c + 1 == 13)));
         if (c + 1 == 8)  chk("b2b s0 cleared", 32'(o_s0), 0);
         if (c + 1 == 13) begin
            chk("b2b score_0", 32'(o_s0), 32'(model(vecs[0].cur, vecs[0].c0, 65535)));
            chk("b2b score_1", 32'(o_s1), 32'(model(vecs[0].cur, vecs[0].c1, 65535)));
            chk("b2b valid",   32'(o_v), 1);
         end
      end
      @(negedge clk);
      set_start(1'b0, 1'b0);

      // Reset in cycle 3 of an operation aborts it without a done.
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         set_start(c == 0, 1'b1);
         reset_N = (c != 3);
         @(posedge clk); #1;
         if (c + 1 == 4) chk_zero("midrst");
         chk($sformatf("midrst done c%0d", c + 1), 32'(o_done), 0);
      end

      // Start coincident with reset loses.
      @(negedge clk);
      set_start(1'b1, 1'b0);
      reset_N = 1'b0;
      @(posedge clk); #1;
      chk("rst+start busy", 32'(o_busy), 0);
      @(negedge clk);
      set_start(1'b0, 1'b0);
      reset_N = 1'b1;

      run_op(vecs[1], "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
